keypad_sync_debounce: RTL
=========================

// Module: keypad_sync_debounce
// PURPOSE
// Parametrised multi-channel input conditioner for asynchronous keypad row lines.
// Each channel passes through an N-stage synchroniser, then a per-channel
// debounce counter, and produces one-cycle rise/fall pulses. Sits between the
// keypad pins and the keypad scan FSM, all in the int_osc domain.
// PARAMETERS
// WIDTH      4   number of independent channels
// STAGES     2   synchroniser flops per channel (legal: >= 2)
// DB_CYCLES  8   consecutive mismatch cycles needed to accept a new level (legal: >= 1)
// RESET_VAL  0   1-bit level loaded into every sync flop and stable bit on reset
// PORTS
// int_osc     in   1      system clock
// reset       in   1      reset, synchronous, active-low
// async_in    in   WIDTH  raw asynchronous inputs (keypad rows)
// hold        in   1      1 = freeze debounce state (scan column switching)
// sync_out    out  WIDTH  synchroniser output, last stage (not debounced)
// stable      out  WIDTH  debounced level
// rise        out  WIDTH  1-cycle pulse: stable[i] went 0->1 this cycle
// fall        out  WIDTH  1-cycle pulse: stable[i] went 1->0 this cycle
// any_stable  out  1      |stable (combinational from registers)
// BEHAVIOUR
// - Reset (reset==0 at posedge): all sync flops and stable = {WIDTH{RESET_VAL}};
//   all counters = 0; rise = fall = 0. Any count or pulse in progress is discarded.
// - Sync chain: shift every cycle, including while hold==1. sync_out lags async_in
//   by STAGES edges.
// - Per channel i, when hold==0:
//   sync_out[i]==stable[i] -> cnt[i] <= 0.
//   mismatch and cnt[i] <  DB_CYCLES-1 -> cnt[i] <= cnt[i]+1.
//   mismatch and cnt[i] == DB_CYCLES-1 -> stable[i] <= sync_out[i]; cnt[i] <= 0;
//   pulse rise[i] or fall[i] (as direction dictates), registered with stable[i].
// - A pulse is high in exactly the first cycle stable[i] shows its new value.
//   It is cleared on the next edge.
// - hold==1: cnt and stable keep their values; rise = fall = 0.
//   Counting resumes where it stopped when hold returns to 0.
// - A mismatch run shorter than DB_CYCLES cycles (glitch) clears the counter:
//   no stable change, no pulse.
// - End-to-end latency (hold==0): input step to stable/pulse is
//   STAGES + DB_CYCLES edges. With DB_CYCLES==1, stable follows sync_out one edge later.
// - Counter width is $clog2(DB_CYCLES+1); counters saturate by design and never wrap.
// - Channels are fully independent. Simultaneous changes on several channels may
//   pulse rise and fall in the same cycle.
// - Elaboration error if STAGES<2 or DB_CYCLES<1.
// TESTING  (WIDTH=4, STAGES=2, DB_CYCLES=8, RESET_VAL=0)
// - reset=0 for 3 cycles with async_in=4'b1010 -> all outputs 0.
//   After release: sync_out=1010 at edge 2, stable=1010 at edge 10, rise=1010 for 1 cycle.
// - async_in[0] 0->1 held -> sync_out[0]=1 after 2 edges; stable[0]=1 and rise[0]=1
//   after 10 edges; rise[0]=0 on the next edge; fall stays 0.
// - async_in[1] high for 7 cycles then low -> stable[1], rise[1], fall[1] remain 0.
//   Repeat the same test with 8 cycles -> stable[1]=1 and rise[1] pulse.
// - Start a 0->1 on bit 2; assert hold after 4 mismatch cycles for 5 cycles
//   -> no change during hold; stable[2]=1 exactly 4 cycles after hold drops.
// - Reset asserted when cnt[3]==5 -> cnt cleared, no pulse. After release,
//   the held input needs the full 2+8 edges again.
// - With stable=0011, switch async_in to 1100 -> after 10 edges, rise=1100 and
//   fall=0011 in the same cycle; any_stable stays 1 throughout.

Source files
------------

// File: rtl/keypad_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : keypad_sync_debounce
// Description : Per-channel N-stage synchroniser and debounce counter for
//               asynchronous keypad rows, with one-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_sync_debounce #(
    parameter int   WIDTH     = 4,
    parameter int   STAGES    = 2,
    parameter int   DB_CYCLES = 8,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic             int_osc,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    input  logic             hold,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_stable
);

    localparam int                 c_cnt_w    = $clog2(DB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

    generate
        if (STAGES < 2 || DB_CYCLES < 1) begin : g_param_check
            $error("keypad_sync_debounce: STAGES must be >= 2 and DB_CYCLES >= 1");
        end
    endgenerate

    logic [WIDTH-1:0]   r_sync [STAGES];
    logic [c_cnt_w-1:0] r_cnt  [WIDTH];
    logic [WIDTH-1:0]   r_stable;
    logic [WIDTH-1:0]   r_rise;
    logic [WIDTH-1:0]   r_fall;

    // The chain keeps shifting during hold so sync_out never goes stale.
    always_ff @(posedge int_osc) begin
        if (!reset) begin
            for (int s = 0; s < STAGES; s++) begin
                r_sync[s] <= {WIDTH{RESET_VAL}};
            end
        end else begin
            r_sync[0] <= async_in;
            for (int s = 1; s < STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign sync_out = r_sync[STAGES-1];

    always_ff @(posedge int_osc) begin
        if (!reset) begin
            r_stable <= {WIDTH{RESET_VAL}};
            r_rise   <= '0;
            r_fall   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_rise <= '0;
            r_fall <= '0;
            if (!hold) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (sync_out[i] == r_stable[i]) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] == c_cnt_last) begin
                        // Counter never passes DB_CYCLES-1, so no wrap is possible.
                        r_stable[i] <= sync_out[i];
                        r_cnt[i]    <= '0;
                        r_rise[i]   <= sync_out[i];
                        r_fall[i]   <= ~sync_out[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign stable     = r_stable;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign any_stable = |r_stable;

endmodule
`default_nettype wire
